// File: rtl/btb_predictor_pkg.sv
// Shared definitions for the branch target buffer: counter encodings and default size.
package btb_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int unsigned BTB_ENTRIES = 16;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating up/down counter with synchronous load and clear.
module sat_ctr2
  import btb_predictor_pkg::*;
#(
  parameter logic [1:0] INIT = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] value
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= INIT;
    end else if (load) begin
      value <= load_val;
    end else if (inc && (value != ST)) begin
      value <= value + 2'd1;
    end else if (dec && (value != SNT)) begin
      value <= value - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: zero-latency lookup for IF,
// training from EX resolution, and saturating performance counters.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned ENTRIES   = BTB_ENTRIES,
  parameter logic [1:0]  INIT_CTR  = 2'b01,
  localparam int unsigned IDX_W    = $clog2(ENTRIES),
  localparam int unsigned TAG_W    = ADDR_SIZE - IDX_W - 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] if_pc,
  input  logic                 if_en,
  output logic                 pred_taken,
  output logic [ADDR_SIZE-1:0] pred_pc,
  input  logic                 upd_en,
  input  logic [ADDR_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [ADDR_SIZE-1:0] upd_target,
  input  logic                 upd_uncond,
  input  logic                 upd_mispredict,
  input  logic                 flush_all,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_updates,
  output logic [31:0]          stat_mispred
);

  logic [ENTRIES-1:0]   valid;
  logic [TAG_W-1:0]     tags    [ENTRIES];
  logic [ADDR_SIZE-1:0] targets [ENTRIES];
  logic [1:0]           ctrs    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             alloc, hit_wr_target;
  logic             ctr_load, ctr_inc, ctr_dec;
  logic [1:0]       ctr_load_val;

  logic [31:0] lookups_q, updates_q, mispred_q;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[ADDR_SIZE-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_SIZE-1:IDX_W+2];

  // Lookup reads the array as it stood before this edge; no same-cycle bypass.
  always_comb begin
    lk_hit     = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    pred_taken = lk_hit && ctrs[lk_idx][1];
    pred_pc    = pred_taken ? targets[lk_idx] : if_pc + ADDR_SIZE'(4);
  end

  always_comb begin
    up_hit        = valid[up_idx] && (tags[up_idx] == up_tag);
    alloc         = upd_en && !up_hit && upd_taken;
    hit_wr_target = upd_en && up_hit && (upd_uncond || upd_taken);
    ctr_load      = (upd_en && up_hit && upd_uncond) || alloc;
    ctr_load_val  = upd_uncond ? ST : WT;
    ctr_inc       = upd_en && up_hit && !upd_uncond && upd_taken;
    ctr_dec       = upd_en && up_hit && !upd_uncond && !upd_taken;
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = (up_idx == IDX_W'(i));

    sat_ctr2 #(.INIT(INIT_CTR)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush_all),
      .load     (ctr_load && sel),
      .load_val (ctr_load_val),
      .inc      (ctr_inc && sel),
      .dec      (ctr_dec && sel),
      .value    (ctrs[i])
    );
  end

  // Tags and targets carry no reset: valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      valid <= '0;
    end else begin
      if (alloc) begin
        valid[up_idx] <= 1'b1;
        tags[up_idx]  <= up_tag;
      end
      if (alloc || hit_wr_target) begin
        targets[up_idx] <= upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lookups_q <= '0;
      updates_q <= '0;
      mispred_q <= '0;
    end else begin
      if (if_en && (lookups_q != '1)) lookups_q <= lookups_q + 32'd1;
      if (upd_en && (updates_q != '1)) updates_q <= updates_q + 32'd1;
      if (upd_en && upd_mispredict && (mispred_q != '1)) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_updates = updates_q;
  assign stat_mispred = mispred_q;

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer with per-entry 2-bit saturating counters. It replaces the single global 2-bit predictor in the IF stage.
- Combinationally looks up the fetch PC and returns a predicted next PC to the PC-select logic.
- Trained one cycle later from the EX-stage branch/jump resolution (same point where hazard detection resolves mispredicts).
- Keeps saturating performance counters for lookups, updates and mispredicts.

Parameters:
- ADDR_SIZE, 32, PC width; matches `ADDR_SIZE.
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).
- INIT_CTR, 2'b01, counter value after reset/flush (weakly not-taken).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_pc  in  ADDR_SIZE  PC of instruction being fetched
- if_en  in  1  fetch advancing (~stall); gates stat_lookups only
- pred_taken  out  1  lookup hit and predicted taken
- pred_pc  out  ADDR_SIZE  predicted next PC
- upd_en  in  1  EX stage holds a resolved branch/jal/jalr this cycle
- upd_pc  in  ADDR_SIZE  PC of the resolved instruction
- upd_taken  in  1  actual outcome (1 for jal/jalr)
- upd_target  in  ADDR_SIZE  actual target address
- upd_uncond  in  1  instruction is jal/jalr
- upd_mispredict  in  1  EX detected wrong next PC
- flush_all  in  1  invalidate every entry
- stat_lookups  out  32  count of cycles with if_en=1
- stat_updates  out  32  count of upd_en=1 cycles
- stat_mispred  out  32  count of upd_en & upd_mispredict

Behaviour:

Address split:
- idx = pc[IDX_W+1:2]
- tag = pc[ADDR_SIZE-1:IDX_W+2]
- pc[1:0] ignored.

Entry contents:
- valid (1), tag, target (ADDR_SIZE), ctr (2).

Lookup (combinational, zero latency):
- hit = valid[idx] & (tag match).
- pred_taken = hit & ctr[1].
- pred_pc = pred_taken ? target : if_pc + 4, wrapping modulo 2^ADDR_SIZE.
- Lookup sees array state from before the current clock edge; there is no bypass of a same-cycle update.

Update (registered, at posedge clk when upd_en=1). Compute hit on upd_pc. Counter saturates at 00 and 11.
- Hit, upd_uncond: ctr←11, target←upd_target.
- Hit, conditional, taken: ctr←min(ctr+1,3), target←upd_target.
- Hit, conditional, not taken: ctr←max(ctr-1,0); target unchanged.
- Miss, taken: allocate/overwrite the entry: valid←1, tag, target←upd_target, ctr←(upd_uncond ? 11 : 10).
- Miss, not taken: no change.

Priority and boundary conditions:
- reset > flush_all > update.
- reset or flush_all: all valid←0, all ctr←INIT_CTR; tags/targets don't-care.
- A same-cycle update is discarded.
- Lookup and update to the same idx in the same cycle: lookup returns old data; the update lands at the edge.
- Aliasing (same idx, different tag) evicts silently.

Reset values:
- All stat counters = 0.
- pred_taken = 0.
- pred_pc = if_pc+4 (all entries invalid).

Stat counters:
- Increment by 1 on their conditions and saturate at 32'hFFFF_FFFF (no wrap).
- Cleared only by reset, not by flush_all.

Implementation notes:
- Storage is flops (no SRAM).
- Expected size is roughly 150–250 lines.

Decomposition:
- Shared defines (existing defines header): counter encodings SNT=00, WNT=01, WT=10, ST=11, and BTB_ENTRIES default.
- One sub-module, sat_ctr2: 2-bit saturating up/down counter with load.
- The stat counters use an inline saturating increment.
- Array and lookup logic stay in btb_predictor.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_pc=0x104; all stat counters 0.
- Update pc=0x100, taken, target=0x200, cond → next cycle lookup 0x100 gives pred_taken=1, pred_pc=0x200 (ctr=10). Then one not-taken update → ctr=01, pred_pc=0x104.
- Three taken updates on 0x100 then one not-taken → still predicted taken (11→10). Two more not-taken → ctr saturates at 00, with no underflow on a third.
- ENTRIES=16: allocate 0x100→0x200, then taken update pc=0x140 (same idx 0, different tag) target 0x300 → lookup 0x100 misses (pred_pc=0x104), lookup 0x140 gives 0x300.
- Same-cycle update and lookup of 0x180 (new allocation) → that cycle pred_pc=0x184, next cycle the target.
- Same-cycle flush_all with an update → entry not allocated.
- jal update pc=0x10 uncond target 0x80 → ctr=11, and upd_mispredict=1 increments stat_mispred to 1.
- Force stat_lookups to 0xFFFF_FFFE, drive if_en=1 for 3 cycles → holds at 0xFFFF_FFFF.
- Assert reset mid-run → all entries invalid and stats 0 on the next cycle.
